// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC mode encoding and instruction constants
// Purpose: mode codes seen on the Mode bus, instruction size, alignment helper.
// Ports: none (package).
package pc_pkg;

  localparam int INSN_BYTES = 4;
  localparam int INSN_SHIFT = 2;  // word offset -> byte offset

  typedef enum logic [2:0] {
    MODE_SEQ  = 3'd0,
    MODE_CBZ  = 3'd1,
    MODE_CBNZ = 3'd2,
    MODE_B    = 3'd3,
    MODE_BL   = 3'd4,
    MODE_BR   = 3'd5,
    MODE_RET  = 3'd6
  } mode_e;

  function automatic logic word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between decoder and PC sequencer
// Purpose: groups the per-cycle next-PC controls and the sequencer outputs.
// Ports (signals):
//   Stall, Mode, SignExt, RegTarget, ALUZero  : driven by master
//   PC, PCPlus4, Fault, RasMismatch, RasCount : driven by slave (sequencer)
interface pc_sequencer_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 4
);

  logic              Stall;
  logic [2:0]        Mode;
  logic [ADDR_W-1:0] SignExt;
  logic [ADDR_W-1:0] RegTarget;
  logic              ALUZero;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus4;
  logic              Fault;
  logic              RasMismatch;
  logic [CNT_W-1:0]  RasCount;

  modport master (
    output Stall, Mode, SignExt, RegTarget, ALUZero,
    input  PC, PCPlus4, Fault, RasMismatch, RasCount
  );

  modport slave (
    input  Stall, Mode, SignExt, RegTarget, ALUZero,
    output PC, PCPlus4, Fault, RasMismatch, RasCount
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with overwrite-on-full
// Purpose: LIFO of return addresses; a push when full silently replaces the
//          oldest entry and the count saturates at DEPTH.
// Ports:
//   Clk     : clock, state updates on falling edge
//   Rst     : synchronous active-low reset (pointer and count only)
//   i_push  : push i_data
//   i_pop   : pop top entry (ignored when empty)
//   i_data  : value to push
//   o_top   : current top entry (stale when o_empty)
//   o_count : number of valid entries
//   o_empty : no valid entries
module pc_ras #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_top,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;    // next slot to write; wraps naturally
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_full;

  assign w_top_idx = r_ptr - 1'b1;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

  // Pointer wraps modulo DEPTH, so a push when full lands on the oldest
  // entry; popping after that still walks back through the newest DEPTH.
  always_ff @(negedge Clk) begin
    if (!Rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (!w_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

  // Contents are not cleared by reset; the count makes stale data invisible.
  always_ff @(negedge Clk) begin
    if (Rst && i_push) begin
      r_mem[r_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection with return-address prediction
// Purpose: registered PC updated every non-stalled cycle from SEQ / conditional
//          / unconditional / register branches; BL pushes the link value, RET
//          pops and flags a prediction miss; misaligned register targets
//          redirect to FAULT_VECTOR.
// Ports:
//   Clk : clock, all state updates on falling edge
//   Rst : synchronous active-low reset
//   bus : pc_sequencer_if slave (Stall, Mode, SignExt, RegTarget, ALUZero in;
//         PC, PCPlus4, Fault, RasMismatch, RasCount out)
module pc_sequencer #(
  parameter int                ADDR_W       = 64,
  parameter int                RAS_DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] FAULT_VECTOR = ADDR_W'('h200)
) (
  input logic           Clk,
  input logic           Rst,
  pc_sequencer_if.slave bus
);

  import pc_pkg::*;

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_fault;
  logic              r_mismatch;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_offset_tgt;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_reg_aligned;
  logic              w_push;
  logic              w_pop;
  logic              w_fault;
  logic              w_mismatch;
  logic [ADDR_W-1:0] w_ras_top;
  logic [CNT_W-1:0]  w_ras_count;
  logic              w_ras_empty;

  assign w_pc_plus4    = r_pc + ADDR_W'(INSN_BYTES);
  assign w_offset_tgt  = r_pc + (bus.SignExt << INSN_SHIFT);
  assign w_reg_aligned = word_aligned(bus.RegTarget[1:0]);

  always_comb begin
    w_next_pc  = w_pc_plus4;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_fault    = 1'b0;
    w_mismatch = 1'b0;
    if (bus.Stall) begin
      w_next_pc = r_pc;
    end else begin
      case (bus.Mode)
        MODE_CBZ: begin
          if (bus.ALUZero) w_next_pc = w_offset_tgt;
        end
        MODE_CBNZ: begin
          if (!bus.ALUZero) w_next_pc = w_offset_tgt;
        end
        MODE_B: begin
          w_next_pc = w_offset_tgt;
        end
        MODE_BL: begin
          w_next_pc = w_offset_tgt;
          w_push    = 1'b1;
        end
        MODE_BR: begin
          if (w_reg_aligned) begin
            w_next_pc = bus.RegTarget;
          end else begin
            w_next_pc = FAULT_VECTOR;
            w_fault   = 1'b1;
          end
        end
        MODE_RET: begin
          // A faulting RET leaves the stack untouched and never reports a miss.
          if (w_reg_aligned) begin
            w_next_pc  = bus.RegTarget;
            w_pop      = 1'b1;
            w_mismatch = w_ras_empty || (w_ras_top != bus.RegTarget);
          end else begin
            w_next_pc = FAULT_VECTOR;
            w_fault   = 1'b1;
          end
        end
        default: begin
          w_next_pc = w_pc_plus4;
        end
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    if (!Rst) begin
      r_pc       <= RESET_VECTOR;
      r_fault    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_fault    <= w_fault;
      r_mismatch <= w_mismatch;
    end
  end

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_plus4),
    .o_top   (w_ras_top),
    .o_count (w_ras_count),
    .o_empty (w_ras_empty)
  );

  assign bus.PC          = r_pc;
  assign bus.PCPlus4     = w_pc_plus4;
  assign bus.Fault       = r_fault;
  assign bus.RasMismatch = r_mismatch;
  assign bus.RasCount    = w_ras_count;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, 64, PC/target width in bits (>= 8).
REQ-002 Parameter RAS_DEPTH, 8, return-address-stack entries (power of two, >= 2).
REQ-003 Parameter RESET_VECTOR, 0, PC value after reset.
REQ-004 Parameter FAULT_VECTOR, 'h200, PC value after a misaligned register branch.
REQ-005 Clk  in  1  single clock; all state updates on negedge Clk.
REQ-006 Rst  in  1  synchronous, active-low reset, sampled on negedge Clk.
REQ-007 Stall  in  1  hold PC and all state this cycle.
REQ-008 Mode  in  3  next-PC mode: SEQ, CBZ, CBNZ, B, BL, BR, RET.
REQ-009 SignExt  in  ADDR_W  sign-extended word offset from instruction.
REQ-010 RegTarget  in  ADDR_W  register-file branch target (BR/RET).
REQ-011 ALUZero  in  1  ALU zero flag for CBZ/CBNZ.
REQ-012 PC  out  ADDR_W  registered current PC.
REQ-013 PCPlus4  out  ADDR_W  combinational PC+4 (BL link value).
REQ-014 Fault  out  1  registered one-cycle pulse: misaligned BR/RET target.
REQ-015 RasMismatch  out  1  registered one-cycle pulse: RET target differs from predicted.
REQ-016 RasCount  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-017 Next PC: SEQ -> PC+4; CBZ -> taken if ALUZero=1; CBNZ -> taken if ALUZero=0; B, BL -> always taken.
REQ-018 Taken offset target = PC + (SignExt << 2); not-taken CBZ/CBNZ -> PC+4.
REQ-019 BR, RET -> RegTarget when RegTarget[1:0]=0, else FAULT_VECTOR with Fault pulsed next cycle.
REQ-020 All arithmetic modulo 2^ADDR_W; shift result truncated to ADDR_W; wrap past all-ones silent.
REQ-021 Unused Mode codes behave as SEQ.
REQ-022 Stall=1: PC, RAS, RasCount held; Fault and RasMismatch drive 0; Mode ignored.
REQ-023 BL (not stalled): push PC+4 onto RAS; RasCount increments.
REQ-024 Push when full: overwrite oldest entry (circular); RasCount saturates at RAS_DEPTH.
REQ-025 RET aligned (not stalled): pop RAS; RasMismatch pulses if RAS empty or popped value != RegTarget.
REQ-026 RET on empty RAS: RasCount stays 0, PC still = RegTarget.
REQ-027 Faulting BR/RET: no RAS push/pop; RasMismatch 0.
REQ-028 Fault and RasMismatch never held more than one cycle without a new triggering event.
REQ-029 PC is the only next-PC source; no internal stall or bubble (latency 1 cycle, every cycle).

Reset
REQ-030 Rst=0 at negedge: PC=RESET_VECTOR, RasCount=0, RAS pointers 0, Fault=0, RasMismatch=0.
REQ-031 Reset overrides Stall and Mode; RAS contents need not be cleared.
REQ-032 Reset mid-sequence discards pending RAS entries; first RET afterwards mismatches.

Structure
REQ-033 Shared package pc_pkg holds Mode encoding (SEQ=0, CBZ=1, CBNZ=2, B=3, BL=4, BR=5, RET=6) and INSN_BYTES=4.
REQ-034 Sub-module pc_ras: parametrised circular LIFO (push, pop, top, count, overwrite-on-full).
REQ-035 Next-PC select combinational in pc_sequencer; only PC, flags and pc_ras hold state.

Verification
REQ-036 Reset then 3 cycles SEQ -> PC 0, 4, 8, 12.
REQ-037 PC=0x100, CBZ, SignExt=-4, ALUZero=1 -> PC=0xF0; same with ALUZero=0 -> 0x104; CBNZ inverse.
REQ-038 PC=0x40 BL SignExt=0x10 -> PC=0x80, RasCount=1; RET RegTarget=0x44 -> PC=0x44, RasMismatch=0; RET again with 0x44 -> RasMismatch=1.
REQ-039 RAS_DEPTH=8: 9 BLs then 9 RETs with matching targets -> RasCount 8, first 8 RETs match, 9th mismatches.
REQ-040 BR RegTarget=0x1002 -> PC=FAULT_VECTOR, Fault one cycle, RasCount unchanged.
REQ-041 Stall=1 with Mode=BL for 2 cycles -> PC and RasCount unchanged; Rst=0 during Stall -> PC=RESET_VECTOR; ADDR_W=8 at PC=0xFC SEQ -> PC=0x00.
